// File: rtl/leading_zero_pkg.sv
// Shared helpers for the leading-zero counter tree.
// The leaf cell counts the leading zeros of one bit pair; an all-zero pair reports 2.
package leading_zero_pkg;

   function automatic logic [1:0] leaf_cnt(input logic [1:0] pair);
      logic [1:0] cnt;
      if (pair[1])
         cnt = 2'd0;
      else if (pair[0])
         cnt = 2'd1;
      else
         cnt = 2'd2;
      return cnt;
   endfunction

endpackage

// File: rtl/leading_zero_node.sv
// Tree-merge cell: combines two half-width leading-zero counts into one.
// An all-zero upper half defers to the lower half, offset by the half width.
module lz_node #(
   parameter int CNT_W = 6,
   parameter int HALF  = 16
) (
   input  logic [CNT_W-1:0] i_cnt_hi,
   input  logic             i_zero_hi,
   input  logic [CNT_W-1:0] i_cnt_lo,
   input  logic             i_zero_lo,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_zero
);

   assign o_cnt  = i_zero_hi ? (CNT_W'(HALF) + i_cnt_lo) : i_cnt_hi;
   assign o_zero = i_zero_hi & i_zero_lo;

endmodule

// File: rtl/leading_zero.sv
// Leading-zero counter built as a log2(WIDTH)-level merge tree, plus a
// registered copy of the count and an all-zero flag qualified by in_valid.
module leading_zero
   import leading_zero_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int IDX_W = $clog2(WIDTH) + 1
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic [WIDTH-1:0] seq,
   output logic [IDX_W-1:0] idx,
   input  logic             in_valid,
   output logic             out_valid,
   output logic [IDX_W-1:0] idx_q,
   output logic             zero_q
);

   localparam int LEVELS = $clog2(WIDTH);
   localparam int LEAVES = WIDTH / 2;

   // Heap layout: node 1 is the root, node n has children 2n (upper) and 2n+1 (lower).
   logic [IDX_W-1:0] w_cnt  [1:WIDTH-1];
   logic             w_zero [1:WIDTH-1];

   logic             r_out_valid;
   logic [IDX_W-1:0] r_idx_q;
   logic             r_zero_q;

   for (genvar j = 0; j < LEAVES; j++) begin : g_leaf
      assign w_cnt[LEAVES+j]  = IDX_W'(leaf_cnt(seq[WIDTH-1-2*j -: 2]));
      assign w_zero[LEAVES+j] = ~|seq[WIDTH-1-2*j -: 2];
   end

   for (genvar l = 0; l < LEVELS - 1; l++) begin : g_lvl
      for (genvar k = 0; k < (1 << l); k++) begin : g_node
         localparam int N = (1 << l) + k;
         lz_node #(
            .CNT_W (IDX_W),
            .HALF  (WIDTH >> (l + 1))
         ) u_node (
            .i_cnt_hi  (w_cnt[2*N]),
            .i_zero_hi (w_zero[2*N]),
            .i_cnt_lo  (w_cnt[2*N+1]),
            .i_zero_lo (w_zero[2*N+1]),
            .o_cnt     (w_cnt[N]),
            .o_zero    (w_zero[N])
         );
      end
   end

   assign idx = w_cnt[1];

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_out_valid <= 1'b0;
         r_idx_q     <= '0;
         r_zero_q    <= 1'b0;
      end else begin
         r_out_valid <= in_valid;
         if (in_valid) begin
            r_idx_q  <= w_cnt[1];
            r_zero_q <= w_zero[1];
         end
      end
   end

   assign out_valid = r_out_valid;
   assign idx_q     = r_idx_q;
   assign zero_q    = r_zero_q;

endmodule

// File: tb/tb_leading_zero.sv
// Bench for leading_zero at WIDTH=8 and WIDTH=32 sharing one clock and reset.
module tb_leading_zero;

   typedef struct packed {
      logic [5:0] idx;
      logic       zero;
   } exp_t;

   logic        CLK;
   logic        RESET_N;
   logic        in_valid;
   logic [7:0]  seq8;
   logic [31:0] seq32;
   logic [3:0]  idx8, idx_q8;
   logic [5:0]  idx32, idx_q32;
   logic        out_valid8, zero_q8, out_valid32, zero_q32;

   int   n_chk  = 0;
   int   n_fail = 0;
   exp_t q8[$];
   exp_t q32[$];
   exp_t last8, last32;

   leading_zero #(.WIDTH(8)) dut8 (
      .CLK(CLK), .RESET_N(RESET_N), .seq(seq8), .idx(idx8), .in_valid(in_valid),
      .out_valid(out_valid8), .idx_q(idx_q8), .zero_q(zero_q8)
   );

   leading_zero #(.WIDTH(32)) dut32 (
      .CLK(CLK), .RESET_N(RESET_N), .seq(seq32), .idx(idx32), .in_valid(in_valid),
      .out_valid(out_valid32), .idx_q(idx_q32), .zero_q(zero_q32)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic int ref_lz(input logic [63:0] v, input int w);
      for (int i = w - 1; i >= 0; i--)
         if (v[i]) return w - 1 - i;
      return w;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // One registered-path cycle: drive, record expectation, clock, compare.
   task automatic step(input logic v, input logic [7:0] s8, input logic [31:0] s32);
      exp_t e8, e32;
      in_valid = v;
      seq8     = s8;
      seq32    = s32;
      if (v) begin
         e8.idx   = 6'(ref_lz({56'd0, s8}, 8));
         e8.zero  = (s8 == 8'd0);
         e32.idx  = 6'(ref_lz({32'd0, s32}, 32));
         e32.zero = (s32 == 32'd0);
         q8.push_back(e8);
         q32.push_back(e32);
      end
      tick();
      check("out_valid8", out_valid8, v);
      check("out_valid32", out_valid32, v);
      if (v) begin
         check("sb8_nonempty", q8.size() != 0, 1);
         check("sb32_nonempty", q32.size() != 0, 1);
         if (q8.size() != 0) begin
            last8 = q8.pop_front();
            check("idx_q8", idx_q8, last8.idx);
            check("zero_q8", zero_q8, last8.zero);
         end
         if (q32.size() != 0) begin
            last32 = q32.pop_front();
            check("idx_q32", idx_q32, last32.idx);
            check("zero_q32", zero_q32, last32.zero);
         end
      end else begin
         check("hold_idx_q8", idx_q8, last8.idx);
         check("hold_zero_q8", zero_q8, last8.zero);
         check("hold_idx_q32", idx_q32, last32.idx);
         check("hold_zero_q32", zero_q32, last32.zero);
      end
   endtask

   logic [7:0]  t8  [5] = '{8'h80, 8'h01, 8'h08, 8'h03, 8'h00};
   int          e8  [5] = '{0, 7, 4, 6, 8};
   logic [31:0] t32 [5] = '{32'h8000_0000, 32'h0000_0001, 32'h0000_0008, 32'h0000_0003, 32'h0};
   int          e32 [5] = '{0, 31, 28, 30, 32};

   initial begin
      logic [31:0] r;
      RESET_N  = 1'b0;
      in_valid = 1'b1;
      seq8     = 8'h80;
      seq32    = 32'h0000_0001;
      last8    = '0;
      last32   = '0;
      tick();
      tick();
      check("rst_out_valid8", out_valid8, 0);
      check("rst_idx_q8", idx_q8, 0);
      check("rst_zero_q8", zero_q8, 0);
      check("rst_out_valid32", out_valid32, 0);
      check("rst_idx_q32", idx_q32, 0);
      check("rst_zero_q32", zero_q32, 0);
      check("rst_comb_idx8", idx8, 0);
      check("rst_comb_idx32", idx32, 31);
      in_valid = 1'b0;
      #2;
      RESET_N = 1'b1;

      for (int i = 0; i < 5; i++) begin
         seq8  = t8[i];
         seq32 = t32[i];
         #1;
         check("dir_idx8", idx8, e8[i]);
         check("dir_idx32", idx32, e32[i]);
      end

      for (int v = 0; v < 256; v++) begin
         seq8 = 8'(v);
         #1;
         check("exh_idx8", idx8, ref_lz({56'd0, seq8}, 8));
      end

      for (int b = 0; b < 32; b++) begin
         seq32 = 32'd1 << b;
         #1;
         check("onehot_idx32", idx32, 31 - b);
      end
      for (int n = 0; n < 200; n++) begin
         r     = $urandom();
         seq32 = r >> $urandom_range(0, 31);
         #1;
         check("rand_idx32", idx32, ref_lz({32'd0, seq32}, 32));
      end

      tick();
      step(1'b1, 8'h10, 32'h0001_0000);
      step(1'b0, 8'hFF, 32'hFFFF_FFFF);
      step(1'b1, 8'h00, 32'h0);
      for (int n = 0; n < 40; n++)
         step(1'($urandom_range(0, 3) != 0), 8'($urandom()) >> $urandom_range(0, 8),
              $urandom() >> $urandom_range(0, 32));

      step(1'b1, 8'h00, 32'h0);
      #3;
      RESET_N = 1'b0;
      seq8    = 8'h20;
      seq32   = 32'h0004_0000;
      #1;
      check("arst_out_valid8", out_valid8, 0);
      check("arst_idx_q8", idx_q8, 0);
      check("arst_zero_q8", zero_q8, 0);
      check("arst_out_valid32", out_valid32, 0);
      check("arst_idx_q32", idx_q32, 0);
      check("arst_zero_q32", zero_q32, 0);
      check("arst_comb_idx8", idx8, 2);
      check("arst_comb_idx32", idx32, 13);
      tick();
      check("arst_hold_valid8", out_valid8, 0);
      q8.delete();
      q32.delete();
      last8  = '0;
      last32 = '0;
      #2;
      RESET_N = 1'b1;
      step(1'b1, 8'h01, 32'h0000_0001);
      step(1'b1, 8'h40, 32'h2000_0000);
      step(1'b0, 8'h00, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
